// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for MIPS DIV/DIVU, stalling the pipeline while it runs.
// Optional DIV_ZERO_FAST_EN: a zero divisor completes straight from IDLE with identical results.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic             annul,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             stall,
  output logic             valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam int CW = $clog2(WIDTH);
  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d, dvs_q, dvs_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d;
  logic             valid_q, valid_d, dbz_q, dbz_d;
  logic [WIDTH-1:0] quo_q, quo_d, rmd_q, rmd_d;
  logic             sa, sb, go, last, zf, load, qbit, fin_qneg, fin_rneg;
  logic [WIDTH-1:0] abs_a, abs_b, step_q, fin_q, fin_r;
  logic [WIDTH+1:0] sh, diff;
  logic [WIDTH:0]   step_r;
  assign sa     = signed_div & a[WIDTH-1];
  assign sb     = signed_div & b[WIDTH-1];
  assign abs_a  = sa ? -a : a;
  assign abs_b  = sb ? -b : b;
  assign go     = (state_q == IDLE) & start & ~annul;
  assign last   = (state_q == RUN) & (cnt_q == CW'(WIDTH - 1));
`ifdef DIV_ZERO_FAST_EN
  assign zf     = go & (b == '0);
`else
  assign zf     = 1'b0;
`endif
  assign load   = (last & ~annul) | zf;
  // rem_q[WIDTH] is always 0 between steps; the extra top bit carries the borrow
  assign sh     = {rem_q, dvd_q[WIDTH-1]};
  assign diff   = sh - {2'b00, dvs_q};
  assign qbit   = ~diff[WIDTH+1];
  assign step_q = {dvd_q[WIDTH-2:0], qbit};
  assign step_r = qbit ? diff[WIDTH:0] : sh[WIDTH:0];
  assign fin_qneg = zf ? sa ^ sb : qneg_q;
  assign fin_rneg = zf ? sa : rneg_q;
  assign fin_q  = zf ? '1 : step_q;
  assign fin_r  = zf ? abs_a : step_r[WIDTH-1:0];
  assign stall  = ~annul & (((state_q == IDLE) & start) | (state_q == RUN));
  assign valid       = valid_q;
  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dbz_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    quo_d   = load ? (fin_qneg ? -fin_q : fin_q) : quo_q;
    rmd_d   = load ? (fin_rneg ? -fin_r : fin_r) : rmd_q;
    dbz_d   = load ? (zf | (dvs_q == '0)) : dbz_q;
    if (annul) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (go) begin
      state_d = zf ? DONE : RUN;
      cnt_d   = '0;
      rem_d   = '0;
      dvd_d   = abs_a;
      dvs_d   = abs_b;
      qneg_d  = sa ^ sb;
      rneg_d  = sa;
    end else if (state_q == RUN) begin
      state_d = last ? DONE : RUN;
      cnt_d   = last ? '0 : cnt_q + 1'b1;
      rem_d   = step_r;
      dvd_d   = step_q;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
    valid_d = (state_d == DONE);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      valid_q <= 1'b0;
      dbz_q   <= 1'b0;
      quo_q   <= '0;
      rmd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      valid_q <= valid_d;
      dbz_q   <= dbz_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed vector table for div_unit plus annul, async-reset and held-start sequences.
module tb_div_unit;
  localparam int W = 32;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         signed_div = 1'b0;
  logic         annul = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         stall, valid, div_by_zero;
  logic [W-1:0] quotient, remainder;
  int applied = 0;
  int miscompares = 0;
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
  } vec_t;
  vec_t v[10];
  div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_div(signed_div), .annul(annul),
    .a(a), .b(b), .stall(stall), .valid(valid), .quotient(quotient),
    .remainder(remainder), .div_by_zero(div_by_zero)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // start is held through the DONE cycle and dropped only after the edge leaving it
  task automatic run(input vec_t t, input int idx);
    int  st;
    bit  seen;
    int  exp_st;
    @(posedge clk); #1;
    a = t.a; b = t.b; signed_div = t.s; start = 1'b1;
    st = 0; seen = 0;
`ifdef DIV_ZERO_FAST_EN
    exp_st = (t.b == 32'd0) ? 1 : W + 1;
`else
    exp_st = W + 1;
`endif
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (valid) seen = 1;
      else st += int'(stall);
    end
    chk($sformatf("v%0d_done", idx), 32'(seen), 32'd1);
    chk($sformatf("v%0d_stall_cycles", idx), 32'(st), 32'(exp_st));
    chk($sformatf("v%0d_stall_in_done", idx), 32'(stall), 32'd0);
    chk($sformatf("v%0d_quotient", idx), quotient, t.q);
    chk($sformatf("v%0d_remainder", idx), remainder, t.r);
    chk($sformatf("v%0d_dbz", idx), 32'(div_by_zero), 32'(t.z));
    @(posedge clk); #1;
    start = 1'b0; a = '0; b = '0;
    @(negedge clk);
    chk($sformatf("v%0d_single_valid", idx), 32'(valid), 32'd0);
    chk($sformatf("v%0d_no_restart", idx), 32'(stall), 32'd0);
  endtask
  initial begin
    int pulses;
    v[0] = '{32'd100,        32'd7,          1'b0, 32'd14,        32'd2,        1'b0};
    v[1] = '{32'hFFFFFFF9,   32'd2,          1'b1, 32'hFFFFFFFD,  32'hFFFFFFFF, 1'b0};
    v[2] = '{32'd7,          32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD,  32'd1,        1'b0};
    v[3] = '{32'h00001234,   32'd0,          1'b0, 32'hFFFFFFFF,  32'h00001234, 1'b1};
    v[4] = '{32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000,  32'd0,        1'b0};
    v[5] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   1'b0, 32'd1,         32'd0,        1'b0};
    v[6] = '{32'hFFFFFFF9,   32'd2,          1'b0, 32'h7FFFFFFC,  32'd1,        1'b0};
    v[7] = '{32'hFFFFFFF9,   32'd0,          1'b1, 32'd1,         32'hFFFFFFF9, 1'b1};
    v[8] = '{32'hFFFFFF9C,   32'hFFFFFFF9,   1'b1, 32'd14,        32'hFFFFFFFE, 1'b0};
    v[9] = '{32'd5,          32'd10,         1'b0, 32'd0,         32'd5,        1'b0};
    #12;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_remainder", remainder, 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) run(v[i], i);
    // annul after 10 RUN steps; prior 14 r 2 must survive
    run(v[0], 10);
    @(posedge clk); #1;
    a = 32'd1000; b = 32'd3; signed_div = 1'b0; start = 1'b1;
    repeat (11) @(posedge clk);
    #1 annul = 1'b1;
    #1 chk("annul_stall_drop", 32'(stall), 32'd0);
    @(posedge clk); #1;
    annul = 1'b0; start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      pulses += int'(valid) + int'(stall);
    end
    chk("annul_no_valid", 32'(pulses), 32'd0);
    chk("annul_keep_quotient", quotient, 32'd14);
    chk("annul_keep_remainder", remainder, 32'd2);
    run(v[1], 11);
    // async reset between edges mid-run
    @(posedge clk); #1;
    a = 32'd1000; b = 32'd3; signed_div = 1'b0; start = 1'b1;
    repeat (21) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; start = 1'b0;
    #1;
    chk("arst_stall", 32'(stall), 32'd0);
    chk("arst_valid", 32'(valid), 32'd0);
    chk("arst_quotient", quotient, 32'd0);
    chk("arst_remainder", remainder, 32'd0);
    #2 rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      pulses += int'(valid);
    end
    chk("arst_no_valid", 32'(pulses), 32'd0);
    run(v[2], 12);
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 restoring divider in the EX stage; executes MIPS DIV/DIVU.
- Holds the pipeline through its stall output while it iterates. Stall drives the enable/clear inputs of the ID/EX and EX/MEM pipeline registers.
- Presents quotient (LO) and remainder (HI) to the EX/MEM register in the cycle the pipeline is released.

Parameters:
- WIDTH, 32, operand and result width in bits; must be >= 2.

Ports:
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-high
- start  input  1  divide instruction present in EX; held high by control until the instruction leaves EX
- signed_div  input  1  1 = DIV (signed), 0 = DIVU; sampled with start
- annul  input  1  synchronous abort (branch/exception flush of EX)
- a  input  WIDTH  dividend; sampled at the start edge
- b  input  WIDTH  divisor; sampled at the start edge
- stall  output  1  combinational; high = hold upstream pipeline registers
- valid  output  1  registered; result available this cycle
- quotient  output  WIDTH  registered quotient (LO)
- remainder  output  WIDTH  registered remainder (HI)
- div_by_zero  output  1  registered; b was 0 for the last completed operation

Behaviour:
- Reset: async rst forces state=IDLE, iteration counter=0, all working registers=0, valid=0, quotient=0, remainder=0, div_by_zero=0.
- States: IDLE, RUN, DONE.
- IDLE -> RUN: when start=1 and annul=0. At that edge:
  - latch |a| and |b|; take absolute value only if signed_div=1 and the MSB is set;
  - latch the result signs: quotient negative = sign(a) XOR sign(b); remainder negative = sign(a); both only when signed_div=1;
  - clear the partial remainder (WIDTH+1 bits) and the counter.
- RUN: one restoring step per cycle:
  - shift {rem, dividend} left by 1;
  - trial-subtract the divisor;
  - if the result is non-negative, keep it and set quotient bit = 1; else set quotient bit = 0.
- RUN ends after exactly WIDTH steps. On the final step edge:
  - transition to DONE;
  - load quotient/remainder with the sign-corrected values (two's-complement negate where the sign is negative);
  - set div_by_zero = (latched b == 0).
- DONE: valid=1 for exactly one cycle; start is ignored; go to IDLE at the next edge.
- valid is 0 in all states other than DONE.
- stall = (state==IDLE & start & ~annul) | (state==RUN).
  - stall is 0 in DONE, so the pipeline advances at the edge that leaves DONE and captures the result.
- Latency with start at edge N:
  - stall is high for WIDTH+1 cycles (the start cycle plus WIDTH RUN cycles);
  - valid is high in the cycle after edge N+WIDTH.
  - For WIDTH=32: 33 stall cycles, valid on cycle 34.
- Divide by zero: the algorithm runs unchanged. Magnitude results are quotient=all ones, remainder=|a|; the signs are then applied and div_by_zero=1.
- Overflow case (signed_div=1, a=most-negative, b=-1): produces quotient=0x80000000, remainder=0. No trap is raised.
- quotient, remainder and div_by_zero hold their values until the next completion. They are never cleared by annul.
- annul is synchronous and overrides start in every state:
  - next state IDLE, counter cleared, valid=0;
  - stall drops in the same cycle annul rises.
- Back-to-back divides: a new start is accepted only from IDLE, which gives a minimum of one idle edge between operations.

Optional Feature:
- Macro: DIV_ZERO_FAST_EN.
- Defined: IDLE with start=1 and b==0 goes directly to DONE at that edge. The results loaded are identical to the full-run results (quotient = sign-applied all ones, remainder = sign-applied |a|, div_by_zero=1). stall is high for 1 cycle only; valid is high in the next cycle.
- Not defined: divide by zero takes the full WIDTH-step path. Outputs are bit-identical to the defined case; only the latency differs.

Test Plan:
- Unsigned divide: DIVU a=100, b=7, start held high → stall high 33 cycles; valid on cycle 34 with quotient=14, remainder=2, div_by_zero=0.
- Signed divide: DIV a=-7 (0xFFFFFFF9), b=2 → quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). DIV a=7, b=-2 → quotient=-3, remainder=1.
- Divide by zero: DIVU a=0x1234, b=0 → quotient=0xFFFFFFFF, remainder=0x1234, div_by_zero=1. Latency is 33 stall cycles without DIV_ZERO_FAST_EN and 1 stall cycle with it.
- Annul mid-run: annul=1 at step 10 → stall falls in that same cycle, state=IDLE, no valid pulse, previous quotient/remainder unchanged. A new start then completes correctly.
- Async reset mid-run: assert rst between clock edges at step 20 → stall, valid, quotient and remainder go to 0 immediately; no valid pulse after release.
- start held through DONE: keep start=1 for one cycle after valid → no second operation begins; stall stays 0.
